// File: rtl/hv_charge_ramp.sv
// hv_charge_ramp: ramps the HV DAC code toward a host-supplied target in bounded
// steps at a fixed tick rate, holds charge_en while charging upward, waits a settle
// interval and then pulses done. abort returns everything to a safe zero state.
module hv_charge_ramp #(
  parameter int unsigned     DW           = 16,
  parameter logic [DW-1:0]   STEP         = 16'd64,
  parameter logic [31:0]     STEP_TICKS   = 32'd100000,
  parameter logic [31:0]     SETTLE_TICKS = 32'd10000000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          set_valid,
  output logic          set_ready,
  input  logic [DW-1:0] set_voltage,
  input  logic          abort,
  output logic [DW-1:0] HVVoltage,
  output logic          charge_en,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    SETTLE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] hv_q, hv_d;
  logic [DW-1:0] target_q, target_d;
  logic [31:0]   tick_q, tick_d;
  logic          charge_en_q, charge_en_d;
  logic          done_q, done_d;
  logic          set_ready_q, set_ready_d;
  logic          busy_q, busy_d;

  // Step arithmetic is done one bit wider than the DAC code so the distance to the
  // target can never wrap, whichever side of the target the current code sits on.
  logic [DW:0]   diff;
  logic [DW:0]   mag;
  logic [DW-1:0] step_mag;
  logic [DW-1:0] hv_up;
  logic [DW-1:0] hv_dn;
  logic          step_now;
  logic          settle_now;

  // Step size toward the target: full STEP, or the remaining distance if smaller.
  always_comb begin
    diff       = {1'b0, target_q} - {1'b0, hv_q};
    mag        = diff[DW] ? (~diff + 1'b1) : diff;
    step_mag   = (mag > {1'b0, STEP}) ? STEP : mag[DW-1:0];
    hv_up      = hv_q + step_mag;
    hv_dn      = hv_q - step_mag;
    step_now   = (tick_q == STEP_TICKS - 32'd1);
    settle_now = (tick_q == SETTLE_TICKS - 32'd1);
  end

  // Next-state and next-output logic; abort overrides every other transition.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    hv_d        = hv_q;
    target_d    = target_q;
    tick_d      = tick_q;
    charge_en_d = charge_en_q;
    done_d      = 1'b0;

    if (abort) begin
      state_d     = IDLE;
      hv_d        = '0;
      tick_d      = '0;
      charge_en_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (set_valid && set_ready_q) begin
            target_d = set_voltage;
            tick_d   = '0;
            if (set_voltage > hv_q) begin
              state_d     = RAMP_UP;
              charge_en_d = 1'b1;
            end else if (set_voltage < hv_q) begin
              state_d     = RAMP_DOWN;
              charge_en_d = 1'b0;
            end else begin
              done_d = 1'b1;
            end
          end
        end

        RAMP_UP: begin
          if (step_now) begin
            tick_d = '0;
            hv_d   = hv_up;
            if (hv_up == target_q) state_d = SETTLE;
          end else begin
            tick_d = tick_q + 32'd1;
          end
        end

        RAMP_DOWN: begin
          if (step_now) begin
            tick_d = '0;
            hv_d   = hv_dn;
            if (hv_dn == target_q) state_d = SETTLE;
          end else begin
            tick_d = tick_q + 32'd1;
          end
        end

        SETTLE: begin
          if (settle_now) begin
            state_d     = IDLE;
            tick_d      = '0;
            charge_en_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            tick_d = tick_q + 32'd1;
          end
        end

        default: begin
          state_d     = IDLE;
          hv_d        = '0;
          tick_d      = '0;
          charge_en_d = 1'b0;
        end
      endcase
    end

    set_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset discards any ramp in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hv_q        <= '0;
      target_q    <= '0;
      tick_q      <= '0;
      charge_en_q <= 1'b0;
      done_q      <= 1'b0;
      set_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q     <= state_d;
      hv_q        <= hv_d;
      target_q    <= target_d;
      tick_q      <= tick_d;
      charge_en_q <= charge_en_d;
      done_q      <= done_d;
      set_ready_q <= set_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign HVVoltage = hv_q;
  assign charge_en = charge_en_q;
  assign done      = done_q;
  assign set_ready = set_ready_q;
  assign busy      = busy_q;

endmodule
